// File: rtl/sc_hazard_unit_if.sv
// sc_hazard_unit_if: signal bundle between the ID/EX pipeline logic and the hazard unit.
//
// master modport: pipeline side. It drives the ID/EX decode fields and the enable strobe,
//                 and receives the selects and stall/flush controls.
// slave modport:  hazard unit side (sc_hazard_unit).
//
// Signals
//   i_enable         pipeline advance strobe (debug step/run)
//   i_id_rs/rt       source register addresses of the instruction in ID
//   i_id_uses_rs/rt  ID instruction actually reads rs / rt
//   i_id_halt        ID instruction is HALT
//   i_ex_wb_addr     destination register of the instruction in EX
//   i_ex_reg_write   EX instruction writes the register file
//   i_ex_mem_read    EX instruction is a load
//   o_sc_src_a/b     EX source mux selects: 00 bus, 01 WB result, 10 MEM-stage ALU result
//   o_stall_pc       hold PC
//   o_stall_if_id    hold IF/ID
//   o_flush_id_ex    load a bubble into ID/EX
//   o_halted         pipeline drained and stopped
interface sc_hazard_unit_if #(
  parameter int unsigned REG_ADDR_SIZE = 5
) ();

  logic                     i_enable;
  logic [REG_ADDR_SIZE-1:0] i_id_rs;
  logic [REG_ADDR_SIZE-1:0] i_id_rt;
  logic                     i_id_uses_rs;
  logic                     i_id_uses_rt;
  logic                     i_id_halt;
  logic [REG_ADDR_SIZE-1:0] i_ex_wb_addr;
  logic                     i_ex_reg_write;
  logic                     i_ex_mem_read;
  logic [1:0]               o_sc_src_a;
  logic [1:0]               o_sc_src_b;
  logic                     o_stall_pc;
  logic                     o_stall_if_id;
  logic                     o_flush_id_ex;
  logic                     o_halted;

  modport master (
    output i_enable,
    output i_id_rs,
    output i_id_rt,
    output i_id_uses_rs,
    output i_id_uses_rt,
    output i_id_halt,
    output i_ex_wb_addr,
    output i_ex_reg_write,
    output i_ex_mem_read,
    input  o_sc_src_a,
    input  o_sc_src_b,
    input  o_stall_pc,
    input  o_stall_if_id,
    input  o_flush_id_ex,
    input  o_halted
  );

  modport slave (
    input  i_enable,
    input  i_id_rs,
    input  i_id_rt,
    input  i_id_uses_rs,
    input  i_id_uses_rt,
    input  i_id_halt,
    input  i_ex_wb_addr,
    input  i_ex_reg_write,
    input  i_ex_mem_read,
    output o_sc_src_a,
    output o_sc_src_b,
    output o_stall_pc,
    output o_stall_if_id,
    output o_flush_id_ex,
    output o_halted
  );

endinterface

// File: rtl/sc_hazard_unit.sv
// sc_hazard_unit: hazard/forwarding controller for the MIPS execute stage.
//
// Keeps a small scoreboard of the writers in MEM and WB, produces registered short-circuit
// selects for the EX source muxes, detects load-use hazards (stall PC and IF/ID, flush ID/EX)
// and sequences a HALT by draining EX, MEM and WB before raising o_halted.
//
// Ports
//   i_clk    clock, rising edge
//   i_reset  synchronous, active-high reset
//   bus      sc_hazard_unit_if.slave; see the interface file for the signal list
//
// Build option
//   SC_HAZARD_FORWARD_EN  defined:   MEM/WB forwarding, only load-use stalls.
//                         undefined: selects tied to 00; any used ID operand that matches the
//                                    EX or MEM writer stalls (WB is covered by write-before-read
//                                    in the register file).
module sc_hazard_unit #(
  parameter int unsigned REG_ADDR_SIZE = 5,
  parameter int unsigned DRAIN_CYCLES  = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  sc_hazard_unit_if.slave  bus
);

  localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CntW-1:0] DrainLoad = CntW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalted
  } state_e;

  typedef logic [REG_ADDR_SIZE-1:0] addr_t;

  // Register 0 is hard-wired: it never forwards and never stalls.
  function automatic logic writer_match(input logic wr, input addr_t waddr, input addr_t r);
    return wr && (waddr != '0) && (waddr == r);
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard: destination of the instructions now in MEM and WB
  // ---------------------------------------------------------------------------
  addr_t mem_addr_q, wb_addr_q;
  logic  mem_valid_q, wb_valid_q;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic load_use;
  logic hazard;

  always_comb begin
    ex_hit_rs  = bus.i_id_uses_rs &
                 writer_match(bus.i_ex_reg_write, bus.i_ex_wb_addr, bus.i_id_rs);
    ex_hit_rt  = bus.i_id_uses_rt &
                 writer_match(bus.i_ex_reg_write, bus.i_ex_wb_addr, bus.i_id_rt);
    mem_hit_rs = bus.i_id_uses_rs & writer_match(mem_valid_q, mem_addr_q, bus.i_id_rs);
    mem_hit_rt = bus.i_id_uses_rt & writer_match(mem_valid_q, mem_addr_q, bus.i_id_rt);
    load_use   = bus.i_ex_mem_read & (ex_hit_rs | ex_hit_rt);
`ifdef SC_HAZARD_FORWARD_EN
    // ALU results forward; only a load in EX cannot supply its data in time.
    hazard     = load_use;
`else
    hazard     = ex_hit_rs | ex_hit_rt | mem_hit_rs | mem_hit_rt;
`endif
  end

  // ---------------------------------------------------------------------------
  // Halt sequencer
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hold;
  logic            halted;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold    = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      StRun: begin
        hold = hazard;
        // A stalled HALT is retaken once the hazard clears.
        if (bus.i_enable && bus.i_id_halt && !hazard) begin
          state_d = StDrain;
          cnt_d   = DrainLoad;
        end
      end
      StDrain: begin
        // HALT itself is turned into a bubble while older instructions retire.
        hold = 1'b1;
        if (bus.i_enable) begin
          if (cnt_q == '0) begin
            state_d = StHalted;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StHalted: begin
        hold   = 1'b1;
        halted = 1'b1;
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_valid_q <= 1'b0;
      wb_addr_q   <= '0;
      wb_valid_q  <= 1'b0;
    end else if (bus.i_enable) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      // EX fields are captured even under a flush: they belong to the real EX instruction.
      mem_addr_q  <= bus.i_ex_wb_addr;
      mem_valid_q <= bus.i_ex_reg_write;
      wb_addr_q   <= mem_addr_q;
      wb_valid_q  <= mem_valid_q;
    end
  end

  assign bus.o_stall_pc    = hold;
  assign bus.o_stall_if_id = hold;
  assign bus.o_flush_id_ex = hold;
  assign bus.o_halted      = halted;

  // ---------------------------------------------------------------------------
  // Short-circuit selects
  // ---------------------------------------------------------------------------
`ifdef SC_HAZARD_FORWARD_EN
  logic [1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;

  // Evaluated for the ID instruction; the writer now in EX is in MEM when it reaches EX.
  always_comb begin
    sel_a_d = ex_hit_rs ? 2'b10 : (mem_hit_rs ? 2'b01 : 2'b00);
    sel_b_d = ex_hit_rt ? 2'b10 : (mem_hit_rt ? 2'b01 : 2'b00);
    if (hold) begin
      sel_a_d = 2'b00;
      sel_b_d = 2'b00;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sel_a_q <= 2'b00;
      sel_b_q <= 2'b00;
    end else if (bus.i_enable) begin
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign bus.o_sc_src_a = sel_a_q;
  assign bus.o_sc_src_b = sel_b_q;

  // WB entry is kept for debug visibility only.
  logic unused_sink;
  assign unused_sink = ^{wb_addr_q, wb_valid_q};
`else
  assign bus.o_sc_src_a = 2'b00;
  assign bus.o_sc_src_b = 2'b00;

  // WB entry is kept for debug visibility only; load_use is subsumed by hazard.
  logic unused_sink;
  assign unused_sink = ^{wb_addr_q, wb_valid_q, load_use};
`endif

endmodule

// File: tb/tb_sc_hazard_unit.sv
// Directed bench for sc_hazard_unit. Expectations follow the build option
// SC_HAZARD_FORWARD_EN (forwarding path when defined, stall-only path otherwise).
module tb_sc_hazard_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sc_hazard_unit_if #(.REG_ADDR_SIZE(5)) bus ();

  sc_hazard_unit #(
    .REG_ADDR_SIZE(5),
    .DRAIN_CYCLES (3)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  logic [2:0] stl;
  assign stl = {bus.o_stall_pc, bus.o_stall_if_id, bus.o_flush_id_ex};

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic halt,
                       input logic [4:0] exa, input logic exw, input logic exm);
    bus.i_enable       = en;
    bus.i_id_rs        = rs;
    bus.i_id_rt        = rt;
    bus.i_id_uses_rs   = urs;
    bus.i_id_uses_rt   = urt;
    bus.i_id_halt      = halt;
    bus.i_ex_wb_addr   = exa;
    bus.i_ex_reg_write = exw;
    bus.i_ex_mem_read  = exm;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_stall", 4'(stl), 4'h0);
    chk("reset_sel_a", 4'(bus.o_sc_src_a), 4'h0);
    chk("reset_sel_b", 4'(bus.o_sc_src_b), 4'h0);
    chk("reset_halted", 4'(bus.o_halted), 4'h0);

`ifdef SC_HAZARD_FORWARD_EN
    // addu r5 in EX, ID reads rs=5 -> MEM forward
    drive(1, 5, 0, 1, 0, 0, 5, 1, 0);
    chk("fwd_no_stall", 4'(stl), 4'h0);
    tick();
    chk("fwd_mem_a", 4'(bus.o_sc_src_a), 4'h2);
    chk("fwd_mem_b", 4'(bus.o_sc_src_b), 4'h0);
    // EX now writes r6; ID reads rt=5 two behind the producer -> WB forward
    drive(1, 0, 5, 0, 1, 0, 6, 1, 0);
    tick();
    chk("fwd_wb_b", 4'(bus.o_sc_src_b), 4'h1);
    chk("fwd_unused_a", 4'(bus.o_sc_src_a), 4'h0);
    // r7 in EX and in MEM scoreboard -> MEM priority
    drive(1, 0, 0, 0, 0, 0, 7, 1, 0);
    tick();
    drive(1, 7, 0, 1, 0, 0, 7, 1, 0);
    tick();
    chk("fwd_prio", 4'(bus.o_sc_src_a), 4'h2);
    drive(1, 7, 0, 1, 0, 0, 8, 1, 0);
    tick();
    chk("fwd_wb_a", 4'(bus.o_sc_src_a), 4'h1);
    // r0 writers in both stages never forward
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(1, 0, 0, 1, 0, 0, 0, 1, 0);
    tick();
    chk("fwd_r0", 4'(bus.o_sc_src_a), 4'h0);
    // lw r3 in EX, ID reads rt=3 -> one-cycle load-use stall
    drive(1, 0, 3, 0, 1, 0, 3, 1, 1);
    chk("lu_stall", 4'(stl), 4'h7);
    tick();
    chk("lu_bubble_b", 4'(bus.o_sc_src_b), 4'h0);
    drive(1, 0, 3, 0, 1, 0, 0, 0, 0);
    chk("lu_release", 4'(stl), 4'h0);
    tick();
    chk("lu_fwd_b", 4'(bus.o_sc_src_b), 4'h1);
    // enable low: nothing updates
    drive(0, 9, 0, 1, 0, 0, 9, 1, 0);
    tick();
    chk("hold_sel_a", 4'(bus.o_sc_src_a), 4'h0);
    chk("hold_sel_b", 4'(bus.o_sc_src_b), 4'h1);
    drive(1, 9, 0, 1, 0, 0, 0, 0, 0);
    tick();
    chk("hold_no_capture", 4'(bus.o_sc_src_a), 4'h0);
`else
    // addu r4-style producer in EX, ID reads rs=5 -> stall for 2 cycles
    drive(1, 5, 0, 1, 0, 0, 5, 1, 0);
    chk("ex_dep_stall", 4'(stl), 4'h7);
    tick();
    chk("sel_a_tied", 4'(bus.o_sc_src_a), 4'h0);
    drive(1, 5, 0, 1, 0, 0, 0, 0, 0);
    chk("mem_dep_stall", 4'(stl), 4'h7);
    tick();
    chk("sel_b_tied", 4'(bus.o_sc_src_b), 4'h0);
    // producer now in WB: no stall
    chk("wb_no_stall", 4'(stl), 4'h0);
    drive(1, 0, 0, 1, 0, 0, 0, 1, 0);
    chk("r0_no_stall", 4'(stl), 4'h0);
    drive(1, 0, 7, 0, 0, 0, 7, 1, 0);
    chk("unused_rt", 4'(stl), 4'h0);
    drive(1, 0, 7, 0, 1, 0, 7, 1, 0);
    chk("used_rt", 4'(stl), 4'h7);
    // enable low: scoreboard does not capture EX
    drive(0, 0, 0, 0, 0, 0, 9, 1, 0);
    tick();
    drive(1, 9, 0, 1, 0, 0, 0, 0, 0);
    chk("hold_no_capture", 4'(stl), 4'h0);
    drive(1, 0, 0, 0, 0, 0, 9, 1, 0);
    tick();
    drive(1, 9, 0, 1, 0, 0, 0, 0, 0);
    chk("enabled_capture", 4'(stl), 4'h7);
`endif

    // load-use together with HALT: stall wins, FSM stays in RUN
    drive(1, 0, 3, 0, 1, 1, 3, 1, 1);
    chk("lu_halt_stall", 4'(stl), 4'h7);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_halt_stays_run", 4'(stl), 4'h0);
    tick();
    tick();

    // HALT drain: entry edge, then 3 enabled edges (one disabled edge in between)
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("run_before_halt", 4'(stl), 4'h0);
    tick();
    chk("drain_stall", 4'(stl), 4'h7);
    chk("drain_not_halted", 4'(bus.o_halted), 4'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("drain_en0", 4'(bus.o_halted), 4'h0);
    chk("drain_en0_stall", 4'(stl), 4'h7);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("drain_1", 4'(bus.o_halted), 4'h0);
    tick();
    chk("drain_2", 4'(bus.o_halted), 4'h0);
    tick();
    chk("halted", 4'(bus.o_halted), 4'h1);
    chk("halted_stall", 4'(stl), 4'h7);
    chk("halted_sel_a", 4'(bus.o_sc_src_a), 4'h0);
    tick();
    chk("halted_sticky", 4'(bus.o_halted), 4'h1);

    // reset out of HALTED
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_halted", 4'(bus.o_halted), 4'h0);
    chk("rst_stall", 4'(stl), 4'h0);
    chk("rst_sel_b", 4'(bus.o_sc_src_b), 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
